// File: rtl/video_timing_gen_pkg.sv
// Shared GPU video package.
// Holds the coordinate width, the default 640x480@60 timing constants and
// small helpers for decoding sync windows. Imported by video_timing_gen and
// its sync_counter sub-module.
package video_timing_gen_pkg;

  localparam int COORD_W = 12;
  typedef logic [COORD_W-1:0] coord_t;

  // Default 640x480 timing (pixel clocks / lines)
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  // True while lo <= pos < lo+len
  function automatic logic in_window(input coord_t pos, input int lo, input int len);
    return (int'(pos) >= lo) && (int'(pos) < lo + len);
  endfunction

  // Drive the polarity level inside the pulse, its complement outside
  function automatic logic sync_level(input logic in_pulse, input logic pol);
    return in_pulse ? pol : ~pol;
  endfunction

endpackage

// File: rtl/video_timing_gen_sync_counter.sv
// sync_counter: wrapping horizontal/vertical position counter pair.
// Ports:
//   clk     - clock
//   srst    - synchronous active-high reset, loads (H_INIT, V_INIT)
//   load    - synchronous load of (H_INIT, V_INIT) (idle / start-of-run)
//   h_next  - position the counter takes at the next clock edge (x)
//   v_next  - position the counter takes at the next clock edge (y)
// The next-state values are exported so the parent can register decoded
// outputs in the same cycle as the position they describe.
module sync_counter
  import video_timing_gen_pkg::*;
#(
  parameter int H_TOTAL = 800,
  parameter int V_TOTAL = 525,
  parameter int H_INIT  = 0,
  parameter int V_INIT  = 0
) (
  input  logic               clk,
  input  logic               srst,
  input  logic               load,
  output logic [COORD_W-1:0] h_next,
  output logic [COORD_W-1:0] v_next
);

  coord_t h_reg;
  coord_t v_reg;

  always_comb begin
    h_next = h_reg;
    v_next = v_reg;
    if (srst || load) begin
      h_next = coord_t'(H_INIT);
      v_next = coord_t'(V_INIT);
    end else if (h_reg == coord_t'(H_TOTAL - 1)) begin
      h_next = '0;
      v_next = (v_reg == coord_t'(V_TOTAL - 1)) ? '0 : v_reg + coord_t'(1);
    end else begin
      h_next = h_reg + coord_t'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      h_reg <= coord_t'(H_INIT);
      v_reg <= coord_t'(V_INIT);
    end else begin
      h_reg <= h_next;
      v_reg <= v_next;
    end
  end

endmodule

// File: rtl/video_timing_gen.sv
// video_timing_gen: raster timing generator with pixel replication,
// prefetch coordinates and frame/line interrupts.
// Ports:
//   clkPixel    - pixel clock (sole clock)
//   reset       - synchronous active-high reset (same state as enable=0)
//   enable      - 1 runs the timing, 0 parks the generator at (0,0) idle
//   line_cmp    - line number that raises line_irq at h_count=H_ACTIVE
//   h_count/v_count - current raster position
//   hsync/vsync - sync outputs, polarity set by HSYNC_POL/VSYNC_POL
//   de          - display enable (active area)
//   fb_x/fb_y   - scaled framebuffer coordinates (0 outside active area)
//   fetch_x/fetch_y/fetch_valid - scaled coordinates PREFETCH cycles ahead
//   frameDrawn  - one-cycle pulse at (0, V_ACTIVE)
//   line_irq    - one-cycle pulse at (H_ACTIVE, line_cmp)
// Every output is a register loaded from the counters' next-state values,
// so all outputs describe the same position with no skew.
module video_timing_gen
  import video_timing_gen_pkg::*;
#(
  parameter int H_ACTIVE   = DEF_H_ACTIVE,
  parameter int H_FP       = DEF_H_FP,
  parameter int H_SYNC     = DEF_H_SYNC,
  parameter int H_BP       = DEF_H_BP,
  parameter int V_ACTIVE   = DEF_V_ACTIVE,
  parameter int V_FP       = DEF_V_FP,
  parameter int V_SYNC     = DEF_V_SYNC,
  parameter int V_BP       = DEF_V_BP,
  parameter bit HSYNC_POL  = 1'b0,
  parameter bit VSYNC_POL  = 1'b0,
  parameter int SCALE_LOG2 = 1,
  parameter int PREFETCH   = 2
) (
  input  logic               clkPixel,
  input  logic               reset,
  input  logic               enable,
  input  logic [COORD_W-1:0] line_cmp,
  output logic [COORD_W-1:0] h_count,
  output logic [COORD_W-1:0] v_count,
  output logic               hsync,
  output logic               vsync,
  output logic               de,
  output logic [COORD_W-1:0] fb_x,
  output logic [COORD_W-1:0] fb_y,
  output logic [COORD_W-1:0] fetch_x,
  output logic [COORD_W-1:0] fetch_y,
  output logic               fetch_valid,
  output logic               frameDrawn,
  output logic               line_irq
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  // Fetch counter parks at (0,0) advanced by PREFETCH cycles
  localparam int FETCH_H0 = PREFETCH % H_TOTAL;
  localparam int FETCH_V0 = (PREFETCH / H_TOTAL) % V_TOTAL;

  // run_reg is low while idle; the first enabled edge after idle loads
  // (0,0) into the counters so that position is displayed with de=1
  // instead of being skipped.
  logic   run_reg;
  logic   load;
  coord_t disp_h, disp_v, fetch_h, fetch_v;

  assign load = ~enable | ~run_reg;

  sync_counter #(
    .H_TOTAL (H_TOTAL),
    .V_TOTAL (V_TOTAL),
    .H_INIT  (0),
    .V_INIT  (0)
  ) u_disp_cnt (
    .clk    (clkPixel),
    .srst   (reset),
    .load   (load),
    .h_next (disp_h),
    .v_next (disp_v)
  );

  sync_counter #(
    .H_TOTAL (H_TOTAL),
    .V_TOTAL (V_TOTAL),
    .H_INIT  (FETCH_H0),
    .V_INIT  (FETCH_V0)
  ) u_fetch_cnt (
    .clk    (clkPixel),
    .srst   (reset),
    .load   (load),
    .h_next (fetch_h),
    .v_next (fetch_v)
  );

  // Decode of the upcoming position
  logic   hsync_next, vsync_next, de_next, fetch_valid_next;
  logic   frame_next, line_next;
  coord_t fb_x_next, fb_y_next, fetch_x_next, fetch_y_next;

  always_comb begin
    hsync_next       = sync_level(in_window(disp_h, H_ACTIVE + H_FP, H_SYNC), HSYNC_POL);
    vsync_next       = sync_level(in_window(disp_v, V_ACTIVE + V_FP, V_SYNC), VSYNC_POL);
    de_next          = (int'(disp_h) < H_ACTIVE) && (int'(disp_v) < V_ACTIVE);
    fetch_valid_next = (int'(fetch_h) < H_ACTIVE) && (int'(fetch_v) < V_ACTIVE);
    fb_x_next        = de_next ? (disp_h >> SCALE_LOG2) : '0;
    fb_y_next        = de_next ? (disp_v >> SCALE_LOG2) : '0;
    fetch_x_next     = fetch_valid_next ? (fetch_h >> SCALE_LOG2) : '0;
    fetch_y_next     = fetch_valid_next ? (fetch_v >> SCALE_LOG2) : '0;
    frame_next       = (disp_h == '0) && (disp_v == coord_t'(V_ACTIVE));
    // v never exceeds V_TOTAL-1, so out-of-range line_cmp never matches
    line_next        = (disp_h == coord_t'(H_ACTIVE)) && (disp_v == line_cmp);
  end

  logic   hsync_reg, vsync_reg, de_reg, fetch_valid_reg, frame_reg, line_reg;
  coord_t h_count_reg, v_count_reg, fb_x_reg, fb_y_reg, fetch_x_reg, fetch_y_reg;

  always_ff @(posedge clkPixel) begin
    if (reset || !enable) begin
      run_reg         <= 1'b0;
      h_count_reg     <= '0;
      v_count_reg     <= '0;
      hsync_reg       <= ~HSYNC_POL;
      vsync_reg       <= ~VSYNC_POL;
      de_reg          <= 1'b0;
      fb_x_reg        <= '0;
      fb_y_reg        <= '0;
      fetch_x_reg     <= '0;
      fetch_y_reg     <= '0;
      fetch_valid_reg <= 1'b0;
      frame_reg       <= 1'b0;
      line_reg        <= 1'b0;
    end else begin
      run_reg         <= 1'b1;
      h_count_reg     <= disp_h;
      v_count_reg     <= disp_v;
      hsync_reg       <= hsync_next;
      vsync_reg       <= vsync_next;
      de_reg          <= de_next;
      fb_x_reg        <= fb_x_next;
      fb_y_reg        <= fb_y_next;
      fetch_x_reg     <= fetch_x_next;
      fetch_y_reg     <= fetch_y_next;
      fetch_valid_reg <= fetch_valid_next;
      frame_reg       <= frame_next;
      line_reg        <= line_next;
    end
  end

  assign h_count     = h_count_reg;
  assign v_count     = v_count_reg;
  assign hsync       = hsync_reg;
  assign vsync       = vsync_reg;
  assign de          = de_reg;
  assign fb_x        = fb_x_reg;
  assign fb_y        = fb_y_reg;
  assign fetch_x     = fetch_x_reg;
  assign fetch_y     = fetch_y_reg;
  assign fetch_valid = fetch_valid_reg;
  assign frameDrawn  = frame_reg;
  assign line_irq    = line_reg;

endmodule

// File: tb/tb_video_timing_gen.sv
// Testbench for video_timing_gen with small timing (H 8/2/3/3, V 4/1/2/1,
// active-low syncs, 2x pixel replication, PREFETCH=3).
// H_TOTAL=16, V_TOTAL=8, frame = 128 cycles.
module tb_video_timing_gen;

  logic        clkPixel = 1'b0;
  logic        reset;
  logic        enable;
  logic [11:0] line_cmp;
  logic [11:0] h_count, v_count, fb_x, fb_y, fetch_x, fetch_y;
  logic        hsync, vsync, de, fetch_valid, frameDrawn, line_irq;

  always #5 clkPixel = ~clkPixel;

  video_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0),
    .SCALE_LOG2(1), .PREFETCH(3)
  ) dut (
    .clkPixel    (clkPixel),
    .reset       (reset),
    .enable      (enable),
    .line_cmp    (line_cmp),
    .h_count     (h_count),
    .v_count     (v_count),
    .hsync       (hsync),
    .vsync       (vsync),
    .de          (de),
    .fb_x        (fb_x),
    .fb_y        (fb_y),
    .fetch_x     (fetch_x),
    .fetch_y     (fetch_y),
    .fetch_valid (fetch_valid),
    .frameDrawn  (frameDrawn),
    .line_irq    (line_irq)
  );

  typedef struct {
    int h, v, hs, vs, de, fbx, fby, fx, fy, fv, fd, li;
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model state: displayed position and running flag
  int m_h = 0, m_v = 0;
  bit m_run = 1'b0;
  int cyc = 0;
  int fd_cnt = 0, de_cnt = 0, li_cnt = 0, last_fd = -1, fd_period = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Push the expected state for this edge, clock, then pop and compare
  task automatic tick();
    exp_t e;
    exp_t g;
    bit   act;
    int   p, fh, fvv;
    act = enable && !reset;
    if (!act || !m_run) begin
      m_h = 0; m_v = 0;
    end else if (m_h == 15) begin
      m_h = 0;
      m_v = (m_v == 7) ? 0 : m_v + 1;
    end else begin
      m_h = m_h + 1;
    end
    m_run = act;
    p   = (m_v * 16 + m_h + 3) % 128;
    fh  = p % 16;
    fvv = p / 16;
    e.h   = m_h;
    e.v   = m_v;
    e.hs  = (act && m_h >= 10 && m_h <= 12) ? 0 : 1;
    e.vs  = (act && m_v >= 5 && m_v <= 6) ? 0 : 1;
    e.de  = (act && m_h < 8 && m_v < 4) ? 1 : 0;
    e.fbx = e.de ? m_h / 2 : 0;
    e.fby = e.de ? m_v / 2 : 0;
    e.fv  = (act && fh < 8 && fvv < 4) ? 1 : 0;
    e.fx  = e.fv ? fh / 2 : 0;
    e.fy  = e.fv ? fvv / 2 : 0;
    e.fd  = (act && m_h == 0 && m_v == 4) ? 1 : 0;
    e.li  = (act && m_h == 8 && m_v == int'(line_cmp)) ? 1 : 0;
    sb_q.push_back(e);
    @(posedge clkPixel);
    #1;
    cyc++;
    g = sb_q.pop_front();
    chk("h_count", int'(h_count), g.h);
    chk("v_count", int'(v_count), g.v);
    chk("hsync", int'(hsync), g.hs);
    chk("vsync", int'(vsync), g.vs);
    chk("de", int'(de), g.de);
    chk("fb_x", int'(fb_x), g.fbx);
    chk("fb_y", int'(fb_y), g.fby);
    chk("fetch_x", int'(fetch_x), g.fx);
    chk("fetch_y", int'(fetch_y), g.fy);
    chk("fetch_valid", int'(fetch_valid), g.fv);
    chk("frameDrawn", int'(frameDrawn), g.fd);
    chk("line_irq", int'(line_irq), g.li);
    if (frameDrawn) begin
      fd_cnt++;
      if (last_fd >= 0) fd_period = cyc - last_fd;
      last_fd = cyc;
    end
    if (de) de_cnt++;
    if (line_irq) li_cnt++;
    $display("cyc=%0d h=%0d v=%0d hs=%0b vs=%0b de=%0b fb=(%0d,%0d) fetch=(%0d,%0d,%0b) fd=%0b li=%0b",
             cyc, h_count, v_count, hsync, vsync, de, fb_x, fb_y, fetch_x, fetch_y,
             fetch_valid, frameDrawn, line_irq);
  endtask

  task automatic run_to(input int h, input int v);
    int n = 0;
    do begin
      tick();
      n++;
    end while (!(m_h == h && m_v == v) && n < 300);
    if (!(m_h == h && m_v == v)) chk("run_to_timeout", n, -1);
  endtask

  typedef struct {
    int lc, h, v, hs, vs, de, fbx, fby, fx, fy, fv, fd, li;
  } vec_t;

  vec_t tbl[10];
  int   fbx_seq[8];

  initial begin
    // lc    h  v  hs vs de fbx fby fx fy fv fd li
    tbl[0] = '{2,  0, 0, 1, 1, 1, 0, 0, 1, 0, 1, 0, 0};
    tbl[1] = '{2, 10, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[2] = '{9, 12, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[3] = '{2, 13, 6, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[4] = '{2, 13, 7, 1, 1, 0, 0, 0, 0, 0, 1, 0, 0};
    tbl[5] = '{4,  0, 4, 1, 1, 0, 0, 0, 0, 0, 0, 1, 0};
    tbl[6] = '{2,  8, 2, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1};
    tbl[7] = '{2,  7, 3, 1, 1, 1, 3, 1, 0, 0, 0, 0, 0};
    tbl[8] = '{2,  5, 0, 1, 1, 1, 2, 0, 0, 0, 0, 0, 0};
    tbl[9] = '{2,  4, 1, 1, 1, 1, 2, 0, 3, 0, 1, 0, 0};
    fbx_seq = '{0, 0, 1, 1, 2, 2, 3, 3};

    // Reset state with enable high: parked at (0,0), syncs inactive
    reset = 1'b1; enable = 1'b1; line_cmp = 12'd0;
    repeat (3) tick();
    chk("rst_h", int'(h_count), 0);
    chk("rst_hsync", int'(hsync), 1);
    chk("rst_vsync", int'(vsync), 1);
    chk("rst_de", int'(de), 0);
    reset = 1'b0;
    tick();
    chk("first_h", int'(h_count), 0);
    chk("first_v", int'(v_count), 0);
    chk("first_de", int'(de), 1);
    tick();
    chk("second_h", int'(h_count), 1);

    // Two full frames: pulse count, period, de count, no line_irq at 9
    line_cmp = 12'd9;
    run_to(15, 7);
    fd_cnt = 0; de_cnt = 0; li_cnt = 0;
    repeat (256) tick();
    chk("frames_fd_cnt", fd_cnt, 2);
    chk("frames_fd_period", fd_period, 128);
    chk("frames_de_cnt", de_cnt, 64);
    chk("lc9_li_cnt", li_cnt, 0);

    // line_cmp=2 fires once per frame; out-of-range value never fires
    line_cmp = 12'd2; li_cnt = 0;
    repeat (128) tick();
    chk("lc2_li_cnt", li_cnt, 1);
    line_cmp = 12'd100; li_cnt = 0;
    repeat (128) tick();
    chk("lc100_li_cnt", li_cnt, 0);

    // Pixel replication along line 1
    run_to(15, 0);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("fbx_seq%0d", i), int'(fb_x), fbx_seq[i]);
    end

    // Reset mid-frame at (6,3), then restart like power-up
    run_to(6, 3);
    reset = 1'b1;
    tick();
    chk("midrst_h", int'(h_count), 0);
    chk("midrst_v", int'(v_count), 0);
    chk("midrst_hsync", int'(hsync), 1);
    chk("midrst_vsync", int'(vsync), 1);
    chk("midrst_de", int'(de), 0);
    reset = 1'b0;
    tick();
    chk("midrst_rel_de", int'(de), 1);
    tick();
    chk("midrst_rel_h", int'(h_count), 1);

    // enable low mid-line idles the generator, then resumes from (0,0)
    run_to(3, 2);
    enable = 1'b0;
    repeat (3) tick();
    chk("idle_fetch_valid", int'(fetch_valid), 0);
    chk("idle_v", int'(v_count), 0);
    enable = 1'b1;
    tick();
    chk("resume_h", int'(h_count), 0);
    chk("resume_de", int'(de), 1);

    // Table of hand-derived points
    for (int k = 0; k < 10; k++) begin
      line_cmp = 12'(tbl[k].lc);
      run_to(tbl[k].h, tbl[k].v);
      chk($sformatf("tbl%0d_h", k), int'(h_count), tbl[k].h);
      chk($sformatf("tbl%0d_v", k), int'(v_count), tbl[k].v);
      chk($sformatf("tbl%0d_hsync", k), int'(hsync), tbl[k].hs);
      chk($sformatf("tbl%0d_vsync", k), int'(vsync), tbl[k].vs);
      chk($sformatf("tbl%0d_de", k), int'(de), tbl[k].de);
      chk($sformatf("tbl%0d_fb_x", k), int'(fb_x), tbl[k].fbx);
      chk($sformatf("tbl%0d_fb_y", k), int'(fb_y), tbl[k].fby);
      chk($sformatf("tbl%0d_fetch_x", k), int'(fetch_x), tbl[k].fx);
      chk($sformatf("tbl%0d_fetch_y", k), int'(fetch_y), tbl[k].fy);
      chk($sformatf("tbl%0d_fetch_valid", k), int'(fetch_valid), tbl[k].fv);
      chk($sformatf("tbl%0d_frameDrawn", k), int'(frameDrawn), tbl[k].fd);
      chk($sformatf("tbl%0d_line_irq", k), int'(line_irq), tbl[k].li);
    end

    chk("sb_empty", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
